// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop, with start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             brw_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic             d_s;
    logic             brw_next_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // Full-subtractor cell on the current LSBs of the operand shifters.
    always_comb begin
        d_s        = fs_diff(a_sh_r[0], b_sh_r[0], brw_r);
        brw_next_s = fs_borrow(a_sh_r[0], b_sh_r[0], brw_r);
    end

    // Control FSM, operand/result shifters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            brw_r    <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            bout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        brw_r    <= bin;
                        res_sh_r <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_sh_r <= {d_s, res_sh_r[WIDTH-1:1]};
                    brw_r    <= brw_next_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_BIT) begin
                        diff_r  <= {d_s, res_sh_r[WIDTH-1:1]};
                        bout_r  <= brw_next_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; it is not queued.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = 4'd0, b4 = 4'd0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'd0, b8 = 8'd0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned operands.
    function automatic logic [31:0] ref_diff(input int x, input int y, input int bi, input int w);
        return 32'((x - y - bi) & ((1 << w) - 1));
    endfunction

    function automatic logic ref_bout(input int x, input int y, input int bi);
        return (x < y + bi);
    endfunction

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic bi, input bit noisy);
        int cycles;
        @(negedge clk);
        a4 = x; b4 = y; bin4 = bi; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("busy4_after_accept", 32'(busy4), 32'd1);
        cycles = 0;
        while (done4 !== 1'b1 && cycles < 20) begin
            chk("busy4_done4_exclusive", 32'(busy4 & done4), 32'd0);
            if (noisy) begin
                a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom); start4 = 1'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
        end
        start4 = 1'b0;
        chk("latency4", 32'(cycles), 32'd4);
        chk("diff4", 32'(diff4), ref_diff(int'(x), int'(y), int'(bi), 4));
        chk("bout4", 32'(bout4), 32'(ref_bout(int'(x), int'(y), int'(bi))));
        chk("busy4_at_done", 32'(busy4), 32'd0);
        @(posedge clk); #1;
        chk("done4_one_cycle", 32'(done4), 32'd0);
        chk("diff4_held", 32'(diff4), ref_diff(int'(x), int'(y), int'(bi), 4));
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int cycles;
        @(negedge clk);
        a8 = x; b8 = y; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cycles = 0;
        while (done8 !== 1'b1 && cycles < 30) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("latency8", 32'(cycles), 32'd8);
        chk("diff8", 32'(diff8), ref_diff(int'(x), int'(y), int'(bi), 8));
        chk("bout8", 32'(bout8), 32'(ref_bout(int'(x), int'(y), int'(bi))));
        @(posedge clk); #1;
        chk("done8_one_cycle", 32'(done8), 32'd0);
    endtask

    initial begin
        int done_at[$];
        int ndone;
        logic [3:0] ca, cb;
        logic cbin;

        // Reset state
        #12;
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_diff4", 32'(diff4), 32'd0);
        chk("rst_bout4", 32'(bout4), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        op4(4'b1011, 4'b0100, 1'b0, 1'b0);
        chk("dir1_diff", 32'(diff4), 32'b0111);
        op4(4'b0100, 4'b1011, 1'b0, 1'b0);
        chk("dir2_diff", 32'(diff4), 32'b1001);
        chk("dir2_bout", 32'(bout4), 32'd1);
        op4(4'b1111, 4'b1101, 1'b1, 1'b0);
        chk("dir3_diff", 32'(diff4), 32'b0001);
        chk("dir3_bout", 32'(bout4), 32'd0);
        op4(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("dir4_diff", 32'(diff4), 32'b1111);
        chk("dir4_bout", 32'(bout4), 32'd1);

        // Inputs churning during RUN must not disturb the sampled operands
        for (int i = 0; i < 10; i++)
            op4(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);

        // start held high: one result every WIDTH+2 cycles
        ca = 4'($urandom); cb = 4'($urandom); cbin = 1'($urandom);
        @(negedge clk);
        a4 = ca; b4 = cb; bin4 = cbin; start4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("cont_exclusive", 32'(busy4 & done4), 32'd0);
            if (done4 === 1'b1) begin
                done_at.push_back(i);
                chk("cont_diff", 32'(diff4), ref_diff(int'(ca), int'(cb), int'(cbin), 4));
                chk("cont_bout", 32'(bout4), 32'(ref_bout(int'(ca), int'(cb), int'(cbin))));
            end
        end
        start4 = 1'b0;
        ndone = done_at.size();
        chk("cont_count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            chk("cont_t0", 32'(done_at[0]), 32'd4);
            chk("cont_t1", 32'(done_at[1]), 32'd10);
            chk("cont_t2", 32'(done_at[2]), 32'd16);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("cont_idle", 32'(busy4), 32'd0);

        // Reset mid-RUN aborts without a done pulse
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_done", 32'(done4), 32'd0);
        chk("abort_diff", 32'(diff4), 32'd0);
        chk("abort_bout", 32'(bout4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        op4(4'd9, 4'd3, 1'b0, 1'b0);

        // Exhaustive WIDTH=4 sweep
        for (int i = 0; i < 512; i++)
            op4(4'(i >> 5), 4'(i >> 1), 1'(i), 1'b0);

        // WIDTH=8 random sweep
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
